// File: rtl/ides_delay_cal_mc_pkg.sv
// Shared state encoding and IDES step-strobe polarities for the multi-lane delay calibrator.
// A tap step is one cycle of value at VALUE_STROBE, with setn giving the direction.
package ides_cal_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_STEP,
        ST_CENTER,
        ST_NEXT,
        ST_DONE
    } cal_state_e;

    localparam logic SETN_INC     = 1'b0;
    localparam logic SETN_DEC     = 1'b1;
    localparam logic VALUE_STROBE = 1'b0;

endpackage

// File: rtl/ides_delay_cal_mc_if.sv
// Lane-array side bundle of the calibrator: deserialised data and recal in, tap controls and status out.
// The master modport is the calibrator and the slave modport is the IDES array / link-training side.
interface ides_delay_cal_mc_if #(
    parameter int NLANE = 4,
    parameter int FW    = 8,
    parameter int TAP_W = 7
);

    logic [NLANE*FW-1:0]    q;
    logic                   recal;
    logic [NLANE-1:0]       sdtap;
    logic [NLANE-1:0]       value;
    logic [NLANE-1:0]       setn;
    logic [NLANE-1:0]       cal;
    logic [NLANE-1:0]       cal_err;
    logic                   cal_done;
    logic [NLANE*TAP_W-1:0] tap;

    modport master (
        input  q,
        input  recal,
        output sdtap,
        output value,
        output setn,
        output cal,
        output cal_err,
        output cal_done,
        output tap
    );

    modport slave (
        output q,
        output recal,
        input  sdtap,
        input  value,
        input  setn,
        input  cal,
        input  cal_err,
        input  cal_done,
        input  tap
    );

endinterface

// File: rtl/ides_delay_cal_mc_run_tracker.sv
// Longest good-tap run tracker: updates cur/best runs once per evaluated tap, ties keep the earlier run.
// Target and pass flag are combinational from the best-run registers; no backpressure.
module ides_run_tracker #(
    parameter int TAP_W   = 7,
    parameter int MIN_EYE = 3
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_sample_en,
    input  logic             i_good,
    input  logic [TAP_W-1:0] i_tap,
    output logic [TAP_W-1:0] o_target,
    output logic             o_pass
);

    localparam logic [TAP_W:0] LEN_ONE = (TAP_W+1)'(1);
    localparam logic [TAP_W:0] MIN_LEN = (TAP_W+1)'(MIN_EYE);

    logic [TAP_W:0]   r_cur_len;
    logic [TAP_W:0]   r_best_len;
    logic [TAP_W-1:0] r_cur_start;
    logic [TAP_W-1:0] r_best_start;

    logic [TAP_W-1:0] w_start;
    logic [TAP_W:0]   w_len_inc;
    logic [TAP_W:0]   w_sum;

    assign w_start   = (r_cur_len == '0) ? i_tap : r_cur_start;
    assign w_len_inc = r_cur_len + LEN_ONE;

    always_ff @(posedge pclk) begin
        if (rst || i_clr) begin
            r_cur_len    <= '0;
            r_best_len   <= '0;
            r_cur_start  <= '0;
            r_best_start <= '0;
        end else if (i_sample_en) begin
            if (i_good) begin
                r_cur_start <= w_start;
                r_cur_len   <= w_len_inc;
                // strict compare keeps the lower run on a tie
                if (w_len_inc > r_best_len) begin
                    r_best_len   <= w_len_inc;
                    r_best_start <= w_start;
                end
            end else begin
                r_cur_len <= '0;
            end
        end
    end

    assign o_pass   = (r_best_len >= MIN_LEN);
    assign w_sum    = {1'b0, r_best_start} + ((r_best_len - LEN_ONE) >> 1);
    assign o_target = o_pass ? w_sum[TAP_W-1:0] : '0;

endmodule

// File: rtl/ides_delay_cal_mc.sv
// Sequential per-lane IDES tap sweep: zero the tap, score every tap for q stability, centre on the widest eye.
// Step strobes are registered, one cycle low, spaced at least one cycle apart; recal restarts from lane 0.
module ides_delay_cal_mc
    import ides_cal_pkg::*;
#(
    parameter int NLANE     = 4,
    parameter int FW        = 8,
    parameter int TAP_W     = 7,
    parameter int MAX_TAP   = 127,
    parameter int SETTLE    = 4,
    parameter int STABLE_N  = 16,
    parameter int MIN_EYE   = 3,
    parameter int INIT_WAIT = 10
) (
    input  logic                 pclk,
    input  logic                 rst,
    ides_delay_cal_mc_if.master  bus
);

    localparam int LANE_W = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int CNT_W  = $clog2(INIT_WAIT + SETTLE + STABLE_N + 1);

    cal_state_e                   r_state;
    cal_state_e                   w_state_nxt;
    logic [LANE_W-1:0]            r_lane;
    logic [CNT_W-1:0]             r_cnt;
    logic [NLANE-1:0][TAP_W-1:0]  r_tap;
    logic [NLANE-1:0]             r_value;
    logic [NLANE-1:0]             r_setn;
    logic [NLANE-1:0]             r_cal;
    logic [NLANE-1:0]             r_cal_err;
    logic                         r_cal_done;
    logic [FW-1:0]                r_q_s;
    logic [FW-1:0]                r_q_p;
    logic                         r_bad;

    logic [FW-1:0]                w_q_lane;
    logic [TAP_W-1:0]             w_cur_tap;
    logic [TAP_W-1:0]             w_target;
    logic                         w_pass;
    logic                         w_changed;
    logic                         w_busy;
    logic                         w_last_lane;
    logic                         w_cnt_clr;
    logic                         w_cnt_inc;
    logic                         w_step_inc;
    logic                         w_step_dec;
    logic                         w_sample_en;
    logic                         w_trk_clr;
    logic                         w_lane_inc;
    logic                         w_lane_zero;
    logic                         w_set_result;
    logic                         w_set_done;
    logic                         w_clr_results;
    logic                         w_bad_clr;
    logic                         w_bad_acc;

    always_comb begin
        w_q_lane  = '0;
        w_cur_tap = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_q_lane  = bus.q[i*FW +: FW];
                w_cur_tap = r_tap[i];
            end
        end
    end

    assign w_changed   = (r_q_s != r_q_p);
    assign w_busy      = (r_value != {NLANE{~VALUE_STROBE}});
    assign w_last_lane = (r_lane == LANE_W'(NLANE - 1));

    ides_run_tracker #(
        .TAP_W   (TAP_W),
        .MIN_EYE (MIN_EYE)
    ) u_run_tracker (
        .pclk        (pclk),
        .rst         (rst),
        .i_clr       (w_trk_clr),
        .i_sample_en (w_sample_en),
        .i_good      (~r_bad),
        .i_tap       (w_cur_tap),
        .o_target    (w_target),
        .o_pass      (w_pass)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_step_inc    = 1'b0;
        w_step_dec    = 1'b0;
        w_sample_en   = 1'b0;
        w_trk_clr     = 1'b0;
        w_lane_inc    = 1'b0;
        w_lane_zero   = 1'b0;
        w_set_result  = 1'b0;
        w_set_done    = 1'b0;
        w_clr_results = 1'b0;
        w_bad_clr     = 1'b0;
        w_bad_acc     = 1'b0;
        if (bus.recal) begin
            w_state_nxt   = ST_CLR;
            w_cnt_clr     = 1'b1;
            w_trk_clr     = 1'b1;
            w_lane_zero   = 1'b1;
            w_clr_results = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_cnt == CNT_W'(INIT_WAIT - 1)) begin
                        w_state_nxt = ST_CLR;
                        w_cnt_clr   = 1'b1;
                        w_lane_zero = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                ST_CLR: begin
                    if (!w_busy) begin
                        if (w_cur_tap == '0) begin
                            w_state_nxt = ST_SETTLE;
                            w_cnt_clr   = 1'b1;
                        end else begin
                            w_step_dec = 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE - 1)) begin
                        w_state_nxt = ST_SAMPLE;
                        w_cnt_clr   = 1'b1;
                        w_bad_clr   = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    w_bad_acc = 1'b1;
                    if (r_cnt == CNT_W'(STABLE_N - 1)) begin
                        w_state_nxt = ST_EVAL;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                ST_EVAL: begin
                    w_sample_en = 1'b1;
                    // strobe is registered so it is low for exactly the STEP cycle
                    if (w_cur_tap < TAP_W'(MAX_TAP)) begin
                        w_state_nxt = ST_STEP;
                        w_step_inc  = 1'b1;
                    end else begin
                        w_state_nxt = ST_CENTER;
                    end
                end
                ST_STEP: begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_clr   = 1'b1;
                end
                ST_CENTER: begin
                    if (!w_busy) begin
                        if (w_cur_tap == w_target) begin
                            w_set_result = 1'b1;
                            w_state_nxt  = ST_NEXT;
                        end else begin
                            w_step_dec = 1'b1;
                        end
                    end
                end
                ST_NEXT: begin
                    w_trk_clr = 1'b1;
                    if (w_last_lane) begin
                        w_state_nxt = ST_DONE;
                        w_set_done  = 1'b1;
                    end else begin
                        w_state_nxt = ST_CLR;
                        w_lane_inc  = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lane     <= '0;
            r_cnt      <= '0;
            r_tap      <= '0;
            r_value    <= {NLANE{~VALUE_STROBE}};
            r_setn     <= '0;
            r_cal      <= '0;
            r_cal_err  <= '0;
            r_cal_done <= 1'b0;
            r_q_s      <= '0;
            r_q_p      <= '0;
            r_bad      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q_s   <= w_q_lane;
            r_q_p   <= r_q_s;

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_bad_clr) begin
                r_bad <= 1'b0;
            end else if (w_bad_acc) begin
                r_bad <= r_bad | w_changed;
            end

            // the tap register moves with the strobe so it always mirrors the delay line
            r_value <= {NLANE{~VALUE_STROBE}};
            for (int i = 0; i < NLANE; i++) begin
                if (r_lane == LANE_W'(i)) begin
                    if (w_step_inc) begin
                        r_value[i] <= VALUE_STROBE;
                        r_setn[i]  <= SETN_INC;
                        r_tap[i]   <= r_tap[i] + TAP_W'(1);
                    end else if (w_step_dec) begin
                        r_value[i] <= VALUE_STROBE;
                        r_setn[i]  <= SETN_DEC;
                        r_tap[i]   <= r_tap[i] - TAP_W'(1);
                    end
                    if (w_set_result) begin
                        r_cal[i]     <= w_pass;
                        r_cal_err[i] <= ~w_pass;
                    end
                end
            end

            if (w_lane_zero) begin
                r_lane <= '0;
            end else if (w_lane_inc) begin
                r_lane <= r_lane + LANE_W'(1);
            end

            if (w_clr_results) begin
                r_cal      <= '0;
                r_cal_err  <= '0;
                r_cal_done <= 1'b0;
            end else if (w_set_done) begin
                r_cal_done <= 1'b1;
            end
        end
    end

    assign bus.sdtap    = '1;
    assign bus.value    = r_value;
    assign bus.setn     = r_setn;
    assign bus.cal      = r_cal;
    assign bus.cal_err  = r_cal_err;
    assign bus.cal_done = r_cal_done;
    assign bus.tap      = r_tap;

endmodule

// File: tb/tb_ides_delay_cal_mc.sv
// Two-lane calibrator bench: IDES model with per-lane tap windows, completion scoreboard and strobe checks.
module tb_ides_delay_cal_mc;

    localparam int NLANE = 2;
    localparam int FW    = 8;
    localparam int TAP_W = 4;

    typedef struct {
        string      name;
        logic [3:0] tap0;
        logic [3:0] tap1;
        logic [1:0] cal;
        logic [1:0] err;
        int         inc0;
        int         dec0;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    ides_delay_cal_mc_if #(.NLANE(NLANE), .FW(FW), .TAP_W(TAP_W)) ides ();

    ides_delay_cal_mc #(
        .NLANE(NLANE), .FW(FW), .TAP_W(TAP_W), .MAX_TAP(15), .SETTLE(2),
        .STABLE_N(8), .MIN_EYE(3), .INIT_WAIT(10)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (ides)
    );

    int n_chk  = 0;
    int n_pass = 0;
    exp_t exp_q[$];

    // IDES model: two good windows per lane; outside them q toggles every cycle
    int lo0[NLANE], hi0[NLANE], lo1[NLANE], hi1[NLANE];
    logic [3:0] mtap[NLANE];
    bit   tog = 1'b0;
    int   inc0 = 0;
    int   dec0 = 0;

    always @(posedge pclk) begin
        tog <= ~tog;
        for (int i = 0; i < NLANE; i++) begin
            if (rst) mtap[i] <= 4'd0;
            else if (!ides.value[i]) mtap[i] <= ides.setn[i] ? mtap[i] - 4'd1 : mtap[i] + 4'd1;
        end
        if (!rst && !ides.value[0]) begin
            if (ides.setn[0]) dec0 <= dec0 + 1;
            else inc0 <= inc0 + 1;
        end
    end

    always_comb begin
        ides.q = '0;
        for (int i = 0; i < NLANE; i++) begin
            logic g;
            g = (int'(mtap[i]) >= lo0[i] && int'(mtap[i]) <= hi0[i]) ||
                (int'(mtap[i]) >= lo1[i] && int'(mtap[i]) <= hi1[i]);
            ides.q[i*FW +: FW] = (g || !tog) ? 8'hA5 : 8'h5A;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_win(input int a0, input int b0, input int c0, input int d0,
                           input int a1, input int b1, input int c1, input int d1);
        lo0[0] = a0; hi0[0] = b0; lo1[0] = c0; hi1[0] = d0;
        lo0[1] = a1; hi0[1] = b1; lo1[1] = c1; hi1[1] = d1;
    endtask

    task automatic push_exp(input string nm, input logic [3:0] t0, input logic [3:0] t1,
                            input logic [1:0] c, input logic [1:0] e, input int ni, input int nd);
        exp_t x;
        x.name = nm; x.tap0 = t0; x.tap1 = t1; x.cal = c; x.err = e;
        x.inc0 = inc0 + ni; x.dec0 = dec0 + nd;
        exp_q.push_back(x);
    endtask

    task automatic pulse_recal();
        @(negedge pclk); ides.recal = 1'b1;
        @(negedge pclk); ides.recal = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge pclk);
            got = ides.cal_done;
        end
        chk({nm, "_done_in_budget"}, 32'(got), 32'd1);
        repeat (3) @(negedge pclk);
    endtask

    // completion monitor and strobe-shape checks
    initial begin
        bit         prev_done = 1'b0;
        bit         prev_strb = 1'b0;
        logic [1:0] prev_setn = 2'b00;
        exp_t       e;
        forever begin
            @(negedge pclk);
            if (ides.cal_done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_tap0"}, 32'(ides.tap[3:0]), 32'(e.tap0));
                    chk({e.name, "_tap1"}, 32'(ides.tap[7:4]), 32'(e.tap1));
                    chk({e.name, "_ides_tap0"}, 32'(mtap[0]), 32'(e.tap0));
                    chk({e.name, "_cal"}, 32'(ides.cal), 32'(e.cal));
                    chk({e.name, "_cal_err"}, 32'(ides.cal_err), 32'(e.err));
                    chk({e.name, "_inc0"}, 32'(inc0), 32'(e.inc0));
                    chk({e.name, "_dec0"}, 32'(dec0), 32'(e.dec0));
                end
            end
            if (ides.value != 2'b11)
                chk("value_onehot_low", 32'($countones(~ides.value)), 32'd1);
            if (prev_strb && !rst)
                chk("setn_stable", 32'(ides.setn), 32'(prev_setn));
            prev_done = ides.cal_done;
            prev_strb = (ides.value != 2'b11);
            prev_setn = ides.setn;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  k;
        int  first;
        bit  hit;
        ides.recal = 1'b0;
        set_win(4, 10, 99, -1, 0, 15, 99, -1);
        repeat (3) @(negedge pclk);
        chk("rst_value", 32'(ides.value), 32'h3);
        chk("rst_setn", 32'(ides.setn), 32'h0);
        chk("rst_cal", 32'(ides.cal), 32'h0);
        chk("rst_cal_err", 32'(ides.cal_err), 32'h0);
        chk("rst_cal_done", 32'(ides.cal_done), 32'h0);
        chk("rst_tap", 32'(ides.tap), 32'h0);
        chk("sdtap", 32'(ides.sdtap), 32'h3);

        // A: lane0 eye 4..10, lane1 fully open
        push_exp("A", 4'd7, 4'd7, 2'b11, 2'b00, 15, 8);
        rst = 1'b0;
        wait_done("A");

        // B/C: lane0 best run 9..13, lane1 eye too narrow
        set_win(2, 3, 9, 13, 6, 7, 99, -1);
        push_exp("BC", 4'd11, 4'd0, 2'b01, 2'b10, 15, 11);
        pulse_recal();
        wait_done("BC");

        // D: equal runs 1..4 and 8..11, the lower wins
        set_win(1, 4, 8, 11, 3, 12, 99, -1);
        push_exp("D", 4'd2, 4'd7, 2'b11, 2'b00, 15, 24);
        pulse_recal();
        wait_done("D");

        // E: recal while lane1 sweeps through tap 9
        set_win(4, 10, 99, -1, 0, 15, 99, -1);
        pulse_recal();
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge pclk);
            hit = (ides.tap[7:4] == 4'd9);
        end
        chk("E_reach_tap9", 32'(hit), 32'd1);
        chk("E_pre_recal_cal", 32'(ides.cal), 32'h1);
        push_exp("E", 4'd7, 4'd7, 2'b11, 2'b00, 15, 15);
        ides.recal = 1'b1;
        @(negedge pclk);
        ides.recal = 1'b0;
        chk("E_recal_cal", 32'(ides.cal), 32'h0);
        chk("E_recal_done", 32'(ides.cal_done), 32'h0);
        wait_done("E");

        // F: reset during an increment strobe on lane0
        pulse_recal();
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge pclk);
            hit = (ides.tap[3:0] == 4'd5) && !ides.value[0] && !ides.setn[0];
        end
        chk("F_reach_step5", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge pclk);
        chk("F_rst_value", 32'(ides.value), 32'h3);
        chk("F_rst_tap", 32'(ides.tap), 32'h0);
        chk("F_rst_cal", 32'(ides.cal), 32'h0);
        chk("F_rst_setn", 32'(ides.setn), 32'h0);
        push_exp("F", 4'd7, 4'd7, 2'b11, 2'b00, 15, 8);
        rst = 1'b0;
        first = 0;
        for (k = 1; k <= 40 && first == 0; k++) begin
            @(negedge pclk);
            if (ides.value != 2'b11) first = k;
        end
        chk("F_first_strobe_cycle", 32'(first), 32'd22);
        wait_done("F");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
